// File: rtl/despacho_pkg.sv
// Shared opcode/class encodings and helpers for the in-order issue unit.
package despacho_pkg;

   localparam logic [3:0] OP_LD   = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic       CLS_ALU = 1'b0;
   localparam logic       CLS_MEM = 1'b1;

   // Isolates the least-significant set bit (two's-complement trick); callers cast down.
   function automatic logic [31:0] lowest_one(input logic [31:0] vec);
      return vec & (~vec + 32'd1);
   endfunction

endpackage

// File: rtl/fila_instrucoes.sv
// Synchronous instruction FIFO with flush priority over push/pop.
module fila_instrucoes #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           flush,
   input  logic [WIDTH-1:0]               data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic [WIDTH-1:0]               head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push & ~full & ~flush;
   assign pop_en  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= data;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         if (push_en && !pop_en)      count <= count + CW'(1);
         else if (pop_en && !push_en) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/unidade_despacho_param.sv
// In-order issue unit: classifies the queue head and issues it to the lowest free station of its class.
module unidade_despacho_param
   import despacho_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4,
   parameter int NUM_ALU = 3,
   parameter int NUM_MEM = 2
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          Flush,
   input  logic                          Instr_Valid,
   input  logic [INSTR_W-1:0]            Instr_In,
   output logic                          Instr_Ready,
   input  logic [NUM_ALU-1:0]            Busy_ALU,
   input  logic [NUM_MEM-1:0]            Busy_MEM,
   output logic                          Disp_Valid,
   output logic [INSTR_W-1:0]            Disp_Instr,
   output logic [NUM_ALU-1:0]            Disp_Sel_ALU,
   output logic [NUM_MEM-1:0]            Disp_Sel_MEM,
   output logic [$clog2(DEPTH+1)-1:0]    Queue_Count,
   output logic                          Stall
);

   logic [INSTR_W-1:0] head;
   logic               full;
   logic               empty;
   logic               head_cls;
   logic [NUM_ALU-1:0] elig_alu;
   logic [NUM_MEM-1:0] elig_mem;
   logic [NUM_ALU-1:0] pick_alu;
   logic [NUM_MEM-1:0] pick_mem;
   logic               can_issue;
   logic               issue;

   fila_instrucoes #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) fila (
      .clk   (Clock),
      .rst_n (Reset),
      .push  (Instr_Valid & Instr_Ready),
      .pop   (issue),
      .flush (Flush),
      .data  (Instr_In),
      .full  (full),
      .empty (empty),
      .count (Queue_Count),
      .head  (head)
   );

   assign Instr_Ready = ~full;

   // The registered select doubles as the pending mask covering the RS busy latency.
   always_comb begin
      head_cls  = (head[INSTR_W-1 -: 4] == OP_LD || head[INSTR_W-1 -: 4] == OP_ST) ? CLS_MEM : CLS_ALU;
      elig_alu  = ~Busy_ALU & ~Disp_Sel_ALU;
      elig_mem  = ~Busy_MEM & ~Disp_Sel_MEM;
      pick_alu  = NUM_ALU'(lowest_one(32'(elig_alu)));
      pick_mem  = NUM_MEM'(lowest_one(32'(elig_mem)));
      can_issue = (head_cls == CLS_MEM) ? |elig_mem : |elig_alu;
      Stall     = ~empty & ~can_issue;
      issue     = ~empty & ~Flush & can_issue;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         Disp_Valid   <= 1'b0;
         Disp_Instr   <= '0;
         Disp_Sel_ALU <= '0;
         Disp_Sel_MEM <= '0;
      end else begin
         Disp_Valid   <= issue;
         if (issue) Disp_Instr <= head;
         Disp_Sel_ALU <= (issue && head_cls == CLS_ALU) ? pick_alu : '0;
         Disp_Sel_MEM <= (issue && head_cls == CLS_MEM) ? pick_mem : '0;
      end
   end

endmodule

// File: doc/unidade_despacho_param.md
Name: unidade_despacho_param

Overview:
- Parametrised in-order issue unit for the Tomasulo datapath; successor to the fixed two-station dispatcher.
- Buffers fetched instructions in a DEPTH-entry queue and classifies the head as ALU or MEM by opcode.
- Issues the head to the lowest-index free reservation station of that class.
- Handles stalls, back-pressure to fetch, flush, and the one-cycle Busy feedback gap.

Parameters:
INSTR_W, 16, instruction width
DEPTH, 4, instruction queue entries (power of 2, >=2)
NUM_ALU, 3, ALU reservation stations
NUM_MEM, 2, load/store reservation stations

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low; clears all state
Flush  in  1  synchronous queue clear (branch mispredict)
Instr_Valid  in  1  fetch presents Instr_In
Instr_In  in  INSTR_W  instruction; opcode = Instr_In[INSTR_W-1:INSTR_W-4]
Instr_Ready  out  1  queue can accept (not full)
Busy_ALU  in  NUM_ALU  per-station busy from ALU RS
Busy_MEM  in  NUM_MEM  per-station busy from MEM RS
Disp_Valid  out  1  one-cycle pulse, instruction issued
Disp_Instr  out  INSTR_W  issued instruction
Disp_Sel_ALU  out  NUM_ALU  one-hot destination (all-zero if MEM)
Disp_Sel_MEM  out  NUM_MEM  one-hot destination (all-zero if ALU)
Queue_Count  out  clog2(DEPTH+1)  occupied entries
Stall  out  1  head valid but no eligible free station (combinational)

Behaviour:
- Reset low (async): queue empty, pointers 0, Queue_Count=0, Disp_Valid=0, Disp_Instr=0, Disp_Sel_*=0, Instr_Ready=1, pending mask=0.
- Push: Instr_Valid & Instr_Ready sampled at rising edge; entry written at tail.
- Instr_Ready = (Queue_Count != DEPTH), from registered count only. A pop in the same cycle does not enable a push when full.
- Classification: opcode OP_LD or OP_ST -> MEM; all other opcodes -> ALU.
- Eligible set: ~Busy_X & ~Pend_X. Pend_X is the registered copy of Disp_Sel_X from the previous cycle; it covers the cycle before the RS raises Busy.
- Issue decision, cycle t: if queue non-empty, no Flush, and eligible set non-empty:
  - pop head;
  - at edge end of t: Disp_Valid=1, Disp_Instr=head, Disp_Sel_class = lowest set bit of eligible set, other class's Disp_Sel=0.
  - Otherwise at that edge: Disp_Valid=0 and Disp_Sel_*=0. Disp_Instr holds its last value.
- At most one issue per cycle; strictly in order. A blocked head blocks younger instructions of the other class.
- Latency: instruction pushed at edge E0 gives earliest Disp_Valid after edge E1. No empty-queue bypass.
- Stall = queue non-empty & eligible set of head class empty.
- Simultaneous push and pop (not full): count unchanged; pointers both advance; wrap modulo DEPTH.
- Flush at edge:
  - pointers and count cleared; Disp_Valid=0, Disp_Sel_*=0 after the edge.
  - Flush wins over push and pop in the same cycle; Pend cleared.
- Reset asserted mid-issue: outputs cleared immediately (async); no partial issue survives.
- Busy inputs are assumed synchronous to Clock.

Decomposition:
- Package despacho_pkg:
  - opcode constants OP_LD=4'h4, OP_ST=4'h5;
  - class encoding CLS_ALU=1'b0, CLS_MEM=1'b1;
  - function lowest_one(vector) returning one-hot.
- Sub-module fila_instrucoes: parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty, count, head.
- Top level holds classification, eligibility, pending mask and output registers.

Test Plan:
- Reset, push ALU opcode 4'h1 with all Busy=0 -> Disp_Valid pulse one cycle after the push edge, Disp_Sel_ALU=3'b001, Disp_Sel_MEM=0, Queue_Count back to 0.
- Push two ALU instrs back-to-back, Busy_ALU held 0 (RS slow) -> issues to 3'b001 then 3'b010 (Pend mask prevents reuse of station 0).
- Busy_MEM=2'b11, push LD (4'h4) then ALU instr -> Stall=1, no Disp_Valid, ALU waits behind LD; drop Busy_MEM[1] -> LD issues with Disp_Sel_MEM=2'b10, ALU issues next cycle.
- All Busy=1, push 5 instrs with DEPTH=4 -> Instr_Ready=0 after 4th, 5th not accepted, Queue_Count=4; free stations -> drain in order, pointers wrap correctly on refill.
- Queue holding 3 entries, assert Flush together with Instr_Valid -> Queue_Count=0, no push, Disp_Valid=0 next cycle.
- Assert Reset low asynchronously between edges while Disp_Valid=1 -> Disp_Valid and Disp_Sel_* go 0 immediately, Instr_Ready=1.
